pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Central stall/bubble/redirect sequencer for the 5-stage RISC-V pipeline (fetch, decode, execute, memory, writeback).
- Sees decode source registers and downstream destination registers, load flags, branch flags and memory busy.
- Drives the per-stage freeze and bubble strobes.
- Runs a branch FSM: fetch is held from the moment a branch/jump leaves decode until writeback resolves it, then fetch is redirected for exactly one cycle.

Parameters:
FWD_EN, 1, 1 = execute has forwarding, so only load-use stalls; 0 = stall on any RAW hit against EXE/MEM/WB destinations.
BR_TIMEOUT, 16, max cycles in BR_WAIT before entering HANG (4..255).
CNT_W, 32, width of the optional stall counter.

Ports:
CLK  in  1  clock, all state on rising edge
RESET  in  1  synchronous, active-low reset
DE_V  in  1  decode latch valid
DE_RS1  in  5  decode rs1
DE_RS2  in  5  decode rs2
DE_USE_RS1  in  1  instruction reads rs1
DE_USE_RS2  in  1  instruction reads rs2
DE_IS_BR  in  1  decode holds branch/JAL/JALR
EXE_V  in  1  execute latch valid
EXE_DR  in  5  execute destination register
EXE_IS_LOAD  in  1  execute holds a load
MEM_V  in  1  memory latch valid
MEM_DR  in  5  memory destination register
MEM_BUSY  in  1  data memory not complete this cycle
WB_V  in  1  writeback latch valid
WB_DR  in  5  writeback destination register
WB_IS_BR  in  1  writeback holds branch/jump
WB_PC_MUX  in  1  writeback branch outcome: 1 = target, 0 = NPC
FE_STALL  out  1  hold PC; fetch writes invalid into decode latch
DE_STALL  out  1  hold decode latch
EXE_BUBBLE  out  1  load execute latch with V=0
MEM_STALL  out  1  freeze FE, DE, EXE and MEM latches
WB_BUBBLE  out  1  load writeback latch with V=0
FE_REDIRECT  out  1  one-cycle PC load strobe
FE_PC_SEL  out  1  PC source during FE_REDIRECT: 1 = target, 0 = NPC
HANG_ERR  out  1  sticky branch-timeout error
STATE  out  2  FSM state for debug
STALL_CNT  out  CNT_W  stall cycle count (optional feature)

Behaviour:
- Reset: when RESET=0 at a clock edge, state <= RUN, timeout counter <= 0, HANG_ERR <= 0, FE_PC_SEL <= 0, STALL_CNT <= 0. All outputs read 0 while in reset and for the first cycle after release.
- FSM states: RUN=0, BR_WAIT=1, BR_REDIR=2, HANG=3.
- RUN:
  - raw_hit (FWD_EN=1): EXE_V & EXE_IS_LOAD & EXE_DR!=0 & ((DE_USE_RS1 & DE_RS1==EXE_DR) | (DE_USE_RS2 & DE_RS2==EXE_DR)).
  - raw_hit (FWD_EN=0): the same compare repeated for EXE, MEM and WB destinations, each qualified by its own V, with load qualification dropped. x0 never hits.
  - DE_V & raw_hit gives FE_STALL=DE_STALL=EXE_BUBBLE=1 combinationally. Repeats every cycle the condition holds.
  - DE_V & DE_IS_BR & !raw_hit & !MEM_BUSY: the branch advances to execute this cycle. Next state BR_WAIT, timeout counter cleared.
- BR_WAIT:
  - FE_STALL=1 constantly, so decode receives only bubbles.
  - Counter increments each cycle, saturating.
  - WB_V & WB_IS_BR: latch FE_PC_SEL <= WB_PC_MUX, next state BR_REDIR.
  - Counter reaching BR_TIMEOUT without resolution: next state HANG.
- BR_REDIR:
  - Exactly one cycle: FE_REDIRECT=1, FE_STALL=0, then RUN.
  - A second branch cannot be in decode here, because decode holds a bubble.
- HANG:
  - FE_STALL=DE_STALL=EXE_BUBBLE=1 and HANG_ERR=1.
  - Exits only on reset.
- MEM_BUSY, in any state except HANG:
  - MEM_STALL=1, WB_BUBBLE=1, DE_STALL=1, FE_STALL=1.
  - EXE_BUBBLE and FE_REDIRECT are forced to 0.
  - FSM holds its state; the timeout counter does not advance.
- Priority: reset > HANG > MEM_BUSY > branch FSM > load-use.
- Simultaneous WB branch resolution and MEM_BUSY: resolution is ignored that cycle. WB is not advancing, so WB_V stays asserted and resolution is taken on the first non-busy cycle.
- Reset asserted mid-BR_WAIT returns to RUN with no redirect issued.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined: STALL_CNT increments by 1 on every cycle with FE_STALL=1 (including HANG). It wraps at 2^CNT_W and clears on reset.
- Undefined: no counter register exists and STALL_CNT is driven to constant 0.

Test Plan:
- Load-use: EXE_V=1, EXE_IS_LOAD=1, EXE_DR=5; DE_V=1, DE_USE_RS1=1, DE_RS1=5 -> FE_STALL=DE_STALL=EXE_BUBBLE=1 for that cycle; same setup with DE_RS1=0 and EXE_DR=0 -> no stall.
- FWD_EN=0: MEM_V=1, MEM_DR=7; DE_RS2=7, DE_USE_RS2=1 -> stall; the same with FWD_EN=1 -> no stall.
- Branch: DE_IS_BR at cycle 0, WB_V=WB_IS_BR=1 with WB_PC_MUX=1 at cycle 3 -> STATE=1 for cycles 1-3; cycle 4 FE_REDIRECT=1, FE_PC_SEL=1, STATE=2; cycle 5 STATE=0.
- MEM_BUSY held 4 cycles during BR_WAIT -> MEM_STALL=WB_BUBBLE=1 for those 4 cycles, timeout counter frozen, redirect delayed by exactly 4 cycles.
- No WB resolution after a branch -> after BR_TIMEOUT=16 cycles STATE=3, HANG_ERR=1 and stays set; RESET=0 for one edge -> STATE=0, HANG_ERR=0.
- PIPE_PERF_CNT_EN defined: 3 load-use stalls plus a 3-cycle branch wait -> STALL_CNT=6; macro undefined -> STALL_CNT=0.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/bubble/redirect sequencer for a 5-stage RISC-V pipeline.
// Optional PIPE_PERF_CNT_EN adds a wrapping count of fetch-stall cycles on stall_cnt_o.
module pipe_hazard_ctrl #(
  parameter bit          FWD_EN     = 1'b1,
  parameter int unsigned BR_TIMEOUT = 16,
  parameter int unsigned CNT_W      = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             de_v_i,
  input  logic [4:0]       de_rs1_i,
  input  logic [4:0]       de_rs2_i,
  input  logic             de_use_rs1_i,
  input  logic             de_use_rs2_i,
  input  logic             de_is_br_i,
  input  logic             exe_v_i,
  input  logic [4:0]       exe_dr_i,
  input  logic             exe_is_load_i,
  input  logic             mem_v_i,
  input  logic [4:0]       mem_dr_i,
  input  logic             mem_busy_i,
  input  logic             wb_v_i,
  input  logic [4:0]       wb_dr_i,
  input  logic             wb_is_br_i,
  input  logic             wb_pc_mux_i,
  output logic             fe_stall_o,
  output logic             de_stall_o,
  output logic             exe_bubble_o,
  output logic             mem_stall_o,
  output logic             wb_bubble_o,
  output logic             fe_redirect_o,
  output logic             fe_pc_sel_o,
  output logic             hang_err_o,
  output logic [1:0]       state_o,
  output logic [CNT_W-1:0] stall_cnt_o
);

  typedef enum logic [1:0] {
    S_RUN      = 2'd0,
    S_BR_WAIT  = 2'd1,
    S_BR_REDIR = 2'd2,
    S_HANG     = 2'd3
  } state_e;

  localparam logic [7:0] TO_LAST = 8'(BR_TIMEOUT - 1);

  state_e     state_q, state_d;
  logic [7:0] to_cnt_q, to_cnt_d;
  logic       hang_err_q, hang_err_d;
  logic       pc_sel_q, pc_sel_d;
  logic       out_en_q;
  logic       active;
  logic       exe_hit, mem_hit, wb_hit, raw_hit;

  function automatic logic src_hit(input logic v, input logic [4:0] dr,
                                   input logic use1, input logic [4:0] rs1,
                                   input logic use2, input logic [4:0] rs2);
    return v && (dr != 5'd0) && ((use1 && (rs1 == dr)) || (use2 && (rs2 == dr)));
  endfunction

  // Without forwarding every older writer hits; with it only a load in execute does.
  assign exe_hit = src_hit(exe_v_i & (exe_is_load_i | !FWD_EN), exe_dr_i,
                           de_use_rs1_i, de_rs1_i, de_use_rs2_i, de_rs2_i);
  assign mem_hit = src_hit(mem_v_i, mem_dr_i, de_use_rs1_i, de_rs1_i, de_use_rs2_i, de_rs2_i);
  assign wb_hit  = src_hit(wb_v_i, wb_dr_i, de_use_rs1_i, de_rs1_i, de_use_rs2_i, de_rs2_i);
  assign raw_hit = exe_hit | (!FWD_EN & (mem_hit | wb_hit));

  // Outputs stay quiet in reset and for the first cycle after release.
  assign active = rst_ni & out_en_q;

  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    fe_stall_o    = 1'b0;
    de_stall_o    = 1'b0;
    exe_bubble_o  = 1'b0;
    mem_stall_o   = 1'b0;
    wb_bubble_o   = 1'b0;
    fe_redirect_o = 1'b0;
    state_d       = state_q;
    to_cnt_d      = to_cnt_q;
    hang_err_d    = hang_err_q;
    pc_sel_d      = pc_sel_q;
    if (active) begin
      if (state_q == S_HANG) begin
        fe_stall_o   = 1'b1;
        de_stall_o   = 1'b1;
        exe_bubble_o = 1'b1;
      end else if (mem_busy_i) begin
        fe_stall_o  = 1'b1;
        de_stall_o  = 1'b1;
        mem_stall_o = 1'b1;
        wb_bubble_o = 1'b1;
      end else begin
        unique case (state_q)
          S_RUN: begin
            if (de_v_i && raw_hit) begin
              fe_stall_o   = 1'b1;
              de_stall_o   = 1'b1;
              exe_bubble_o = 1'b1;
            end else if (de_v_i && de_is_br_i) begin
              state_d  = S_BR_WAIT;
              to_cnt_d = 8'd0;
            end
          end
          S_BR_WAIT: begin
            fe_stall_o = 1'b1;
            if (wb_v_i && wb_is_br_i) begin
              pc_sel_d = wb_pc_mux_i;
              state_d  = S_BR_REDIR;
            end else if (to_cnt_q >= TO_LAST) begin
              state_d    = S_HANG;
              hang_err_d = 1'b1;
            end else if (to_cnt_q != 8'hFF) begin
              to_cnt_d = to_cnt_q + 8'd1;
            end
          end
          S_BR_REDIR: begin
            fe_redirect_o = 1'b1;
            state_d       = S_RUN;
          end
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!rst_ni) begin
      state_q    <= S_RUN;
      to_cnt_q   <= 8'd0;
      hang_err_q <= 1'b0;
      pc_sel_q   <= 1'b0;
      out_en_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      to_cnt_q   <= to_cnt_d;
      hang_err_q <= hang_err_d;
      pc_sel_q   <= pc_sel_d;
      out_en_q   <= 1'b1;
    end
  end

  assign state_o     = active ? state_q : S_RUN;
  assign hang_err_o  = active & hang_err_q;
  assign fe_pc_sel_o = active & pc_sel_q;

`ifdef PIPE_PERF_CNT_EN
  logic [CNT_W-1:0] stall_cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      stall_cnt_q <= '0;
    end else if (fe_stall_o) begin
      stall_cnt_q <= stall_cnt_q + CNT_W'(1);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: one forwarding and one non-forwarding instance share stimulus.
module tb_pipe_hazard_ctrl;

  localparam int CNT_W = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n;
  logic       de_v, de_use_rs1, de_use_rs2, de_is_br;
  logic [4:0] de_rs1, de_rs2, exe_dr, mem_dr, wb_dr;
  logic       exe_v, exe_is_load, mem_v, mem_busy, wb_v, wb_is_br, wb_pc_mux;

  // {fe_stall, de_stall, exe_bubble, mem_stall, wb_bubble, fe_redirect, fe_pc_sel, hang_err, state[1:0]}
  wire [9:0]       obs1, obs0;
  wire [CNT_W-1:0] cnt1, cnt0;

  pipe_hazard_ctrl #(.FWD_EN(1'b1), .BR_TIMEOUT(16), .CNT_W(CNT_W)) dut_fwd (
    .clk_i(clk), .rst_ni(rst_n),
    .de_v_i(de_v), .de_rs1_i(de_rs1), .de_rs2_i(de_rs2),
    .de_use_rs1_i(de_use_rs1), .de_use_rs2_i(de_use_rs2), .de_is_br_i(de_is_br),
    .exe_v_i(exe_v), .exe_dr_i(exe_dr), .exe_is_load_i(exe_is_load),
    .mem_v_i(mem_v), .mem_dr_i(mem_dr), .mem_busy_i(mem_busy),
    .wb_v_i(wb_v), .wb_dr_i(wb_dr), .wb_is_br_i(wb_is_br), .wb_pc_mux_i(wb_pc_mux),
    .fe_stall_o(obs1[9]), .de_stall_o(obs1[8]), .exe_bubble_o(obs1[7]),
    .mem_stall_o(obs1[6]), .wb_bubble_o(obs1[5]), .fe_redirect_o(obs1[4]),
    .fe_pc_sel_o(obs1[3]), .hang_err_o(obs1[2]), .state_o(obs1[1:0]),
    .stall_cnt_o(cnt1)
  );

  pipe_hazard_ctrl #(.FWD_EN(1'b0), .BR_TIMEOUT(16), .CNT_W(CNT_W)) dut_nofwd (
    .clk_i(clk), .rst_ni(rst_n),
    .de_v_i(de_v), .de_rs1_i(de_rs1), .de_rs2_i(de_rs2),
    .de_use_rs1_i(de_use_rs1), .de_use_rs2_i(de_use_rs2), .de_is_br_i(de_is_br),
    .exe_v_i(exe_v), .exe_dr_i(exe_dr), .exe_is_load_i(exe_is_load),
    .mem_v_i(mem_v), .mem_dr_i(mem_dr), .mem_busy_i(mem_busy),
    .wb_v_i(wb_v), .wb_dr_i(wb_dr), .wb_is_br_i(wb_is_br), .wb_pc_mux_i(wb_pc_mux),
    .fe_stall_o(obs0[9]), .de_stall_o(obs0[8]), .exe_bubble_o(obs0[7]),
    .mem_stall_o(obs0[6]), .wb_bubble_o(obs0[5]), .fe_redirect_o(obs0[4]),
    .fe_pc_sel_o(obs0[3]), .hang_err_o(obs0[2]), .state_o(obs0[1:0]),
    .stall_cnt_o(cnt0)
  );

  int checks = 0;
  int errors = 0;

  string      tag_q[$];
  logic [9:0] exp1_q[$];
  logic [9:0] exp0_q[$];

  function automatic logic [9:0] ev(input logic fe, de, exb, ms, wbb, rd, sel, hg,
                                    input logic [1:0] st);
    return {fe, de, exb, ms, wbb, rd, sel, hg, st};
  endfunction

  function automatic logic [9:0] e_idle(input logic sel); return ev(0,0,0,0,0,0,sel,0,2'd0); endfunction
  function automatic logic [9:0] e_lu(input logic sel);   return ev(1,1,1,0,0,0,sel,0,2'd0); endfunction
  function automatic logic [9:0] e_bw(input logic sel);   return ev(1,0,0,0,0,0,sel,0,2'd1); endfunction
  function automatic logic [9:0] e_rd(input logic sel);   return ev(0,0,0,0,0,1,sel,0,2'd2); endfunction
  function automatic logic [9:0] e_busy(input logic sel, input logic [1:0] st);
    return ev(1,1,0,1,1,0,sel,0,st);
  endfunction
  function automatic logic [9:0] e_hang(); return ev(1,1,1,0,0,0,0,1,2'd3); endfunction

  task automatic clr();
    de_v = 0; de_rs1 = 0; de_rs2 = 0; de_use_rs1 = 0; de_use_rs2 = 0; de_is_br = 0;
    exe_v = 0; exe_dr = 0; exe_is_load = 0;
    mem_v = 0; mem_dr = 0; mem_busy = 0;
    wb_v = 0; wb_dr = 0; wb_is_br = 0; wb_pc_mux = 0;
  endtask

  task automatic set_lu(input logic [4:0] dr);
    exe_v = 1; exe_is_load = 1; exe_dr = dr;
    de_v = 1; de_use_rs1 = 1; de_rs1 = dr;
  endtask

  task automatic compare_next();
    string      t;
    logic [9:0] x1, x0;
    t  = tag_q.pop_front();
    x1 = exp1_q.pop_front();
    x0 = exp0_q.pop_front();
    checks++;
    assert (obs1 === x1) else begin
      errors++;
      $error("FAIL %s fwd: observed %b expected %b", t, obs1, x1);
    end
    checks++;
    assert (obs0 === x0) else begin
      errors++;
      $error("FAIL %s nofwd: observed %b expected %b", t, obs0, x0);
    end
  endtask

  // Inputs are applied at the falling edge; outputs are sampled 2 ns later.
  task automatic step(input string tag, input logic [9:0] e1, input logic [9:0] e0);
    tag_q.push_back(tag);
    exp1_q.push_back(e1);
    exp0_q.push_back(e0);
    #2;
    compare_next();
    @(negedge clk);
  endtask

  task automatic check_cnt(input string tag, input logic [CNT_W-1:0] got,
                           input logic [CNT_W-1:0] want);
    checks++;
    assert (got === want) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, want);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [CNT_W-1:0] exp_cnt_fwd, exp_cnt_nofwd, zero_cnt;
`ifdef PIPE_PERF_CNT_EN
    exp_cnt_fwd   = 6;
    exp_cnt_nofwd = 9;
`else
    exp_cnt_fwd   = 0;
    exp_cnt_nofwd = 0;
`endif
    zero_cnt = 0;

    rst_n = 0;
    clr();
    @(negedge clk);
    step("in_reset", 10'd0, 10'd0);

    rst_n = 1;
    set_lu(5'd5);
    step("first_cycle_after_release", 10'd0, 10'd0);
    step("load_use_1", e_lu(0), e_lu(0));
    step("load_use_2", e_lu(0), e_lu(0));

    clr(); set_lu(5'd0);
    step("x0_no_hit", e_idle(0), e_idle(0));
    clr(); set_lu(5'd5); de_rs1 = 5'd6;
    step("rs_mismatch", e_idle(0), e_idle(0));
    clr(); set_lu(5'd5); de_use_rs1 = 0;
    step("rs1_unused", e_idle(0), e_idle(0));
    clr(); set_lu(5'd5); exe_is_load = 0;
    step("exe_alu_raw", e_idle(0), e_lu(0));
    clr(); mem_v = 1; mem_dr = 5'd7; de_v = 1; de_use_rs2 = 1; de_rs2 = 5'd7;
    step("mem_raw_rs2", e_idle(0), e_lu(0));
    clr(); wb_v = 1; wb_dr = 5'd3; de_v = 1; de_use_rs1 = 1; de_rs1 = 5'd3;
    step("wb_raw_rs1", e_idle(0), e_lu(0));
    clr(); exe_v = 1; exe_is_load = 1; exe_dr = 5'd9; de_v = 1; de_use_rs2 = 1; de_rs2 = 5'd9;
    step("load_use_rs2", e_lu(0), e_lu(0));

    // Branch taken, resolved in writeback three cycles after leaving decode.
    clr(); de_v = 1; de_is_br = 1;
    step("br_issue", e_idle(0), e_idle(0));
    clr();
    step("br_wait_1", e_bw(0), e_bw(0));
    step("br_wait_2", e_bw(0), e_bw(0));
    wb_v = 1; wb_is_br = 1; wb_pc_mux = 1;
    step("br_wait_resolve", e_bw(0), e_bw(0));
    clr();
    step("br_redirect_target", e_rd(1), e_rd(1));
    step("br_back_to_run", e_idle(1), e_idle(1));
    check_cnt("stall_cnt_fwd", cnt1, exp_cnt_fwd);
    check_cnt("stall_cnt_nofwd", cnt0, exp_cnt_nofwd);

    // Memory busy inside BR_WAIT, with resolution arriving while busy.
    clr(); de_v = 1; de_is_br = 1;
    step("br2_issue", e_idle(1), e_idle(1));
    clr();
    step("br2_wait", e_bw(1), e_bw(1));
    for (int i = 0; i < 4; i++) begin
      mem_busy = 1;
      if (i >= 2) begin wb_v = 1; wb_is_br = 1; wb_pc_mux = 0; end
      step($sformatf("br2_busy_%0d", i), e_busy(1, 2'd1), e_busy(1, 2'd1));
    end
    mem_busy = 0;
    step("br2_resolve_after_busy", e_bw(1), e_bw(1));
    clr();
    step("br2_redirect_npc", e_rd(0), e_rd(0));
    step("br2_run", e_idle(0), e_idle(0));

    // Memory busy outranks load-use and branch advance in RUN.
    clr(); set_lu(5'd5); mem_busy = 1;
    step("busy_over_load_use", e_busy(0, 2'd0), e_busy(0, 2'd0));
    clr(); de_v = 1; de_is_br = 1; mem_busy = 1;
    step("busy_blocks_branch", e_busy(0, 2'd0), e_busy(0, 2'd0));
    clr();
    step("branch_not_taken_in", e_idle(0), e_idle(0));

    // Timeout: 16 non-busy BR_WAIT cycles, split by 4 frozen busy cycles.
    clr(); de_v = 1; de_is_br = 1;
    step("br3_issue", e_idle(0), e_idle(0));
    clr();
    for (int i = 0; i < 8; i++) step($sformatf("br3_wait_a%0d", i), e_bw(0), e_bw(0));
    mem_busy = 1;
    for (int i = 0; i < 4; i++) step($sformatf("br3_busy_%0d", i), e_busy(0, 2'd1), e_busy(0, 2'd1));
    mem_busy = 0;
    for (int i = 0; i < 8; i++) step($sformatf("br3_wait_b%0d", i), e_bw(0), e_bw(0));
    step("hang", e_hang(), e_hang());
    mem_busy = 1;
    step("hang_over_busy", e_hang(), e_hang());
    clr(); wb_v = 1; wb_is_br = 1; wb_pc_mux = 1;
    step("hang_ignores_wb", e_hang(), e_hang());

    clr(); rst_n = 0;
    step("hang_reset", 10'd0, 10'd0);
    rst_n = 1;
    step("hang_reset_release", 10'd0, 10'd0);
    step("hang_cleared", e_idle(0), e_idle(0));
    check_cnt("stall_cnt_after_reset", cnt1, zero_cnt);

    // Reset in the middle of BR_WAIT drops the branch without a redirect.
    clr(); de_v = 1; de_is_br = 1;
    step("br4_issue", e_idle(0), e_idle(0));
    clr();
    step("br4_wait", e_bw(0), e_bw(0));
    rst_n = 0; wb_v = 1; wb_is_br = 1; wb_pc_mux = 1;
    step("br4_reset", 10'd0, 10'd0);
    rst_n = 1; clr();
    step("br4_release", 10'd0, 10'd0);
    step("br4_no_redirect", e_idle(0), e_idle(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
